iob_cache_wtb_ctrl: RTL and testbench
=====================================

IOB_CACHE_WTB_CTRL -- requirements
Module: iob_cache_wtb_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: backend byte/word address width carried per entry.
REQ-002 SHALL have parameter DATA_W, default 32: write data width; strobe width is DATA_W/8.
REQ-003 SHALL have parameter WTB_MEM_ADDR_W, default 4: buffer depth is 2^WTB_MEM_ADDR_W entries.
REQ-004 SHALL have port clk_i  in  1  the single clock; reset is synchronous and active-high.
REQ-005 SHALL have port rst_i  in  1  synchronous active-high reset, sampled on the rising edge of clk_i.
REQ-006 SHALL have port cke_i  in  1  clock enable; when 0, every register holds.
REQ-007 SHALL have ports wr_valid_i 1 / wr_addr_i ADDR_W / wr_wdata_i DATA_W / wr_wstrb_i DATA_W/8 (in): the cache write request to enqueue.
REQ-008 SHALL have port wr_ready_o  out  1  buffer not full; push accepted when wr_valid_i & wr_ready_o.
REQ-009 SHALL have ports mem_w_en_o 1 / mem_w_addr_o WTB_MEM_ADDR_W / mem_w_data_o MEM_W (out): RAM write port, MEM_W = ADDR_W+DATA_W+DATA_W/8.
REQ-010 SHALL have ports mem_r_en_o 1 / mem_r_addr_o WTB_MEM_ADDR_W (out) and mem_r_data_i MEM_W (in): RAM read port with 1-cycle registered read latency.
REQ-011 SHALL have ports be_iob_avalid_o 1 / be_iob_addr_o ADDR_W / be_iob_wdata_o DATA_W / be_iob_wstrb_o DATA_W/8 (out), be_iob_ready_i 1 (in): backend IOb write.
REQ-012 SHALL have ports empty_o 1, full_o 1, level_o WTB_MEM_ADDR_W+1 (out): occupancy status.

Function
REQ-013 SHALL pack RAM words as {addr, wdata, wstrb}, MSB to LSB.
REQ-014 SHALL drive mem_w_en_o = wr_valid_i & wr_ready_o combinationally, with mem_w_addr_o = write pointer.
REQ-015 SHALL advance the write pointer and the read pointer modulo 2^WTB_MEM_ADDR_W; wrap from 2^W-1 to 0.
REQ-016 SHALL count in level_o every entry pushed and not yet accepted by the backend, including the entry in flight.
REQ-017 SHALL assert full_o when level_o == 2^WTB_MEM_ADDR_W, assert empty_o when level_o == 0, and drive wr_ready_o = ~full_o.
REQ-018 SHALL ignore wr_valid_i while full, with no RAM write and no pointer or level change.
REQ-019 SHALL leave level_o unchanged on a simultaneous push and backend handshake in the same cycle, with both pointers advancing.
REQ-020 SHALL implement FSM IDLE -> FETCH -> REQ -> IDLE.
REQ-021 In IDLE with level_o != 0, SHALL assert mem_r_en_o for one cycle with mem_r_addr_o = read pointer and go to FETCH; otherwise it stays in IDLE.
REQ-022 In FETCH, SHALL register mem_r_data_i into the be_iob_addr/wdata/wstrb output registers and go to REQ.
REQ-023 In REQ, SHALL hold be_iob_avalid_o = 1 with stable addr/wdata/wstrb until be_iob_ready_i = 1.
REQ-024 On the REQ handshake, SHALL increment the read pointer, decrement the level, and return to IDLE.
REQ-025 SHALL produce be_iob_avalid_o 3 cycles after a push into an empty buffer (push cycle t, read t+1, capture t+2, avalid t+3).
REQ-026 SHALL never read RAM in the cycle that RAM location is written, because level_o updates one cycle after the push.
REQ-027 SHALL assert be_iob_avalid_o only in REQ.

Reset
REQ-028 On rst_i, SHALL set the FSM to IDLE and set pointers=0, level_o=0, empty_o=1, full_o=0, wr_ready_o=1, be_iob_avalid_o=0, and addr/wdata/wstrb=0.
REQ-029 On rst_i mid-operation, SHALL discard buffered entries and drop an outstanding be_iob_avalid_o on the next edge without completing it.
REQ-030 SHALL give rst_i priority over cke_i.

Structure
REQ-031 SHALL define the FSM state encodings and the MEM_W width macro in a shared iob_cache_wtb header, also used by the parent when sizing iob_ram_2p.
REQ-032 SHALL have no sub-module; the parent instantiates the RAM (iob_ram_2p) outside this block.

Verification
REQ-033 Bench SHALL cover: push one entry (addr 0x10, data 0xA5A5A5A5, wstrb 0xF) into empty buffer with ready=1 -> avalid at t+3 with those values for 1 cycle, then empty_o=1.
REQ-034 Bench SHALL cover: 16 pushes with ready held 0 (depth 16) -> full_o=1, wr_ready_o=0, and a 17th push ignored; after release, 16 writes drain in push order.
REQ-035 Bench SHALL cover: 20 pushes interleaved with random ready -> pointer wrap, with backend addr sequence matching push order and no loss.
REQ-036 Bench SHALL cover: push in the same cycle as a REQ handshake at level 3 -> level stays 3.
REQ-037 Bench SHALL cover: rst_i asserted while avalid=1 and level 5 -> next cycle avalid=0, level 0, empty_o=1.
REQ-038 Bench SHALL cover: cke_i=0 for 4 cycles during REQ -> all outputs frozen, and the transfer completes after cke_i returns to 1.

Source files
------------

// File: rtl/iob_cache_wtb_ctrl_pkg.sv
// Shared definitions for the write-through buffer controller and its parent,
// which sizes the external two-port RAM from the same word-width helper.
package iob_cache_wtb_ctrl_pkg;

    typedef enum logic [1:0] {
        WTB_IDLE  = 2'd0,
        WTB_FETCH = 2'd1,
        WTB_REQ   = 2'd2
    } wtb_state_e;

    // RAM word is {addr, wdata, wstrb}
    function automatic int wtb_mem_w(input int addr_w, input int data_w);
        return addr_w + data_w + data_w / 8;
    endfunction

endpackage

// File: rtl/iob_cache_wtb_ctrl.sv
// Write-through buffer controller: queues cache writes into an external RAM
// and replays them one at a time on the backend IOb write port.
module iob_cache_wtb_ctrl
    import iob_cache_wtb_ctrl_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int WTB_MEM_ADDR_W = 4,
    localparam int STRB_W        = DATA_W / 8,
    localparam int MEM_W         = wtb_mem_w(ADDR_W, DATA_W)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cke_i,
    input  logic                      wr_valid_i,
    input  logic [ADDR_W-1:0]         wr_addr_i,
    input  logic [DATA_W-1:0]         wr_wdata_i,
    input  logic [STRB_W-1:0]         wr_wstrb_i,
    output logic                      wr_ready_o,
    output logic                      mem_w_en_o,
    output logic [WTB_MEM_ADDR_W-1:0] mem_w_addr_o,
    output logic [MEM_W-1:0]          mem_w_data_o,
    output logic                      mem_r_en_o,
    output logic [WTB_MEM_ADDR_W-1:0] mem_r_addr_o,
    input  logic [MEM_W-1:0]          mem_r_data_i,
    output logic                      be_iob_avalid_o,
    output logic [ADDR_W-1:0]         be_iob_addr_o,
    output logic [DATA_W-1:0]         be_iob_wdata_o,
    output logic [STRB_W-1:0]         be_iob_wstrb_o,
    input  logic                      be_iob_ready_i,
    output logic                      empty_o,
    output logic                      full_o,
    output logic [WTB_MEM_ADDR_W:0]   level_o
);

    localparam int LVL_W = WTB_MEM_ADDR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH = {1'b1, {WTB_MEM_ADDR_W{1'b0}}};
    localparam logic [LVL_W-1:0] LVL_ONE = {{(LVL_W-1){1'b0}}, 1'b1};
    localparam logic [WTB_MEM_ADDR_W-1:0] PTR_ONE = {{(WTB_MEM_ADDR_W-1){1'b0}}, 1'b1};

    wtb_state_e                state_r;
    wtb_state_e                state_nxt_s;
    logic [WTB_MEM_ADDR_W-1:0] wptr_r;
    logic [WTB_MEM_ADDR_W-1:0] rptr_r;
    logic [LVL_W-1:0]          level_r;
    logic                      avalid_r;
    logic [ADDR_W-1:0]         addr_r;
    logic [DATA_W-1:0]         wdata_r;
    logic [STRB_W-1:0]         wstrb_r;
    logic                      full_s;
    logic                      empty_s;
    logic                      push_s;
    logic                      hs_s;
    logic                      rd_s;

    assign full_s  = (level_r == DEPTH);
    assign empty_s = (level_r == {LVL_W{1'b0}});
    assign push_s  = wr_valid_i & ~full_s;
    // avalid_r is only ever set while in REQ, so this is the REQ handshake
    assign hs_s    = avalid_r & be_iob_ready_i;

    // Next-state decode; the RAM read is issued on leaving IDLE
    always_comb begin
        state_nxt_s = state_r;
        rd_s        = 1'b0;
        case (state_r)
            WTB_IDLE: begin
                if (!empty_s) begin
                    rd_s        = 1'b1;
                    state_nxt_s = WTB_FETCH;
                end else begin
                    state_nxt_s = WTB_IDLE;
                end
            end
            WTB_FETCH: state_nxt_s = WTB_REQ;
            WTB_REQ: begin
                if (be_iob_ready_i) begin
                    state_nxt_s = WTB_IDLE;
                end else begin
                    state_nxt_s = WTB_REQ;
                end
            end
            default: state_nxt_s = WTB_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= WTB_IDLE;
        end else if (cke_i) begin
            state_r <= state_nxt_s;
        end
    end

    // Pointers and occupancy; level includes the entry held in the output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_r  <= {WTB_MEM_ADDR_W{1'b0}};
            rptr_r  <= {WTB_MEM_ADDR_W{1'b0}};
            level_r <= {LVL_W{1'b0}};
        end else if (cke_i) begin
            if (push_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (hs_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
            case ({push_s, hs_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Backend request registers: loaded from RAM in FETCH, held until accepted
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            avalid_r <= 1'b0;
            addr_r   <= {ADDR_W{1'b0}};
            wdata_r  <= {DATA_W{1'b0}};
            wstrb_r  <= {STRB_W{1'b0}};
        end else if (cke_i) begin
            if (state_r == WTB_FETCH) begin
                avalid_r                    <= 1'b1;
                {addr_r, wdata_r, wstrb_r} <= mem_r_data_i;
            end else if (hs_s) begin
                avalid_r <= 1'b0;
            end
        end
    end

    assign wr_ready_o      = ~full_s;
    assign mem_w_en_o      = push_s;
    assign mem_w_addr_o    = wptr_r;
    assign mem_w_data_o    = {wr_addr_i, wr_wdata_i, wr_wstrb_i};
    assign mem_r_en_o      = rd_s;
    assign mem_r_addr_o    = rptr_r;
    assign be_iob_avalid_o = avalid_r;
    assign be_iob_addr_o   = addr_r;
    assign be_iob_wdata_o  = wdata_r;
    assign be_iob_wstrb_o  = wstrb_r;
    assign empty_o         = empty_s;
    assign full_o          = full_s;
    assign level_o         = level_r;

endmodule

// File: tb/tb_iob_cache_wtb_ctrl.sv
// Self-checking bench: a queue-based scoreboard predicts occupancy and the
// backend write order; directed sequences cover latency, full, reset and cke.
module tb_iob_cache_wtb_ctrl;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int SW    = 4;
    localparam int MAW   = 4;
    localparam int MW    = AW + DW + SW;
    localparam int DEPTH = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           cke;
    logic           wr_valid;
    logic [AW-1:0]  wr_addr;
    logic [DW-1:0]  wr_wdata;
    logic [SW-1:0]  wr_wstrb;
    logic           wr_ready;
    logic           mem_w_en;
    logic [MAW-1:0] mem_w_addr;
    logic [MW-1:0]  mem_w_data;
    logic           mem_r_en;
    logic [MAW-1:0] mem_r_addr;
    logic [MW-1:0]  mem_r_data;
    logic           be_avalid;
    logic [AW-1:0]  be_addr;
    logic [DW-1:0]  be_wdata;
    logic [SW-1:0]  be_wstrb;
    logic           be_ready;
    logic           empty;
    logic           full;
    logic [MAW:0]   level;

    int             n_checks = 0;
    int             n_errors = 0;
    bit             started  = 1'b0;
    int             m_sz;
    logic [MW-1:0]  ram [DEPTH];
    logic [MW-1:0]  exp_q [$];

    always #5 clk = ~clk;

    iob_cache_wtb_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cke_i           (cke),
        .wr_valid_i      (wr_valid),
        .wr_addr_i       (wr_addr),
        .wr_wdata_i      (wr_wdata),
        .wr_wstrb_i      (wr_wstrb),
        .wr_ready_o      (wr_ready),
        .mem_w_en_o      (mem_w_en),
        .mem_w_addr_o    (mem_w_addr),
        .mem_w_data_o    (mem_w_data),
        .mem_r_en_o      (mem_r_en),
        .mem_r_addr_o    (mem_r_addr),
        .mem_r_data_i    (mem_r_data),
        .be_iob_avalid_o (be_avalid),
        .be_iob_addr_o   (be_addr),
        .be_iob_wdata_o  (be_wdata),
        .be_iob_wstrb_o  (be_wstrb),
        .be_iob_ready_i  (be_ready),
        .empty_o         (empty),
        .full_o          (full),
        .level_o         (level)
    );

    // Two-port RAM with registered read, as the parent would instantiate
    always @(posedge clk) begin
        if (mem_w_en) ram[mem_w_addr] <= mem_w_data;
        if (mem_r_en) mem_r_data <= ram[mem_r_addr];
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: FIFO of accepted writes, compared mid-cycle, then advanced
    always @(negedge clk) begin
        if (started) begin
            m_sz = exp_q.size();
            check("level", level, m_sz);
            check("empty", empty, m_sz == 0);
            check("full", full, m_sz == DEPTH);
            check("wr_ready", wr_ready, m_sz < DEPTH);
            check("mem_w_en", mem_w_en, wr_valid && (m_sz < DEPTH));
            if (be_avalid) begin
                check("avalid_has_data", m_sz != 0, 1'b1);
                if (m_sz != 0) check("be_word", {be_addr, be_wdata, be_wstrb}, exp_q[0]);
            end
            if (rst) begin
                exp_q.delete();
            end else if (cke) begin
                if (be_avalid && be_ready && m_sz > 0) void'(exp_q.pop_front());
                if (wr_valid && m_sz < DEPTH) exp_q.push_back({wr_addr, wr_wdata, wr_wstrb});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_wdata = d;
        wr_wstrb = s;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic wait_avalid(input int maxc);
        int c = 0;
        while (!be_avalid && c < maxc) begin
            step();
            c++;
        end
        check("avalid_timeout", be_avalid, 1'b1);
    endtask

    task automatic wait_empty(input int maxc);
        int c = 0;
        while (!empty && c < maxc) begin
            step();
            c++;
        end
        check("drain_timeout", empty, 1'b1);
    endtask

    initial begin
        int pushed;
        int c;
        rst      = 1'b1;
        cke      = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_wdata = '0;
        wr_wstrb = '0;
        be_ready = 1'b0;
        step();
        started = 1'b1;
        rst     = 1'b0;

        // reset state
        check("rst_level", level, 0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_wr_ready", wr_ready, 1'b1);
        check("rst_avalid", be_avalid, 1'b0);
        check("rst_be_addr", be_addr, 0);
        check("rst_be_wdata", be_wdata, 0);
        check("rst_be_wstrb", be_wstrb, 0);

        // single push: avalid exactly three cycles later, for one cycle
        be_ready = 1'b1;
        push(32'h10, 32'hA5A5A5A5, 4'hF);
        check("lat_t1", be_avalid, 1'b0);
        step();
        check("lat_t2", be_avalid, 1'b0);
        step();
        check("lat_t3", be_avalid, 1'b1);
        check("lat_addr", be_addr, 32'h10);
        check("lat_wdata", be_wdata, 32'hA5A5A5A5);
        check("lat_wstrb", be_wstrb, 4'hF);
        step();
        check("lat_t4_avalid", be_avalid, 1'b0);
        check("lat_t4_empty", empty, 1'b1);

        // fill to depth with backend stalled, then overflow attempt
        be_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) push(32'h1000 + 32'(i * 4), 32'($urandom), 4'($urandom));
        check("fill_full", full, 1'b1);
        check("fill_wr_ready", wr_ready, 1'b0);
        check("fill_level", level, DEPTH);
        wr_valid = 1'b1;
        wr_addr  = 32'hDEAD0000;
        wr_wdata = 32'hDEADBEEF;
        wr_wstrb = 4'h3;
        #1;
        check("ovf_mem_w_en", mem_w_en, 1'b0);
        step();
        wr_valid = 1'b0;
        check("ovf_level", level, DEPTH);
        be_ready = 1'b1;
        wait_empty(200);

        // 20 pushes with random backend ready: pointers wrap
        pushed = 0;
        c      = 0;
        while (pushed < 20 && c < 400) begin
            wr_valid = 1'b1;
            wr_addr  = {28'($urandom), 4'h0};
            wr_wdata = 32'($urandom);
            wr_wstrb = 4'($urandom);
            be_ready = 1'($urandom_range(0, 1));
            if (wr_ready) pushed++;
            step();
            c++;
        end
        wr_valid = 1'b0;
        check("wrap_push_count", pushed, 20);
        be_ready = 1'b1;
        wait_empty(200);

        // push coinciding with a backend handshake at level 3
        be_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(32'h2000 + 32'(i * 4), 32'($urandom), 4'hF);
        wait_avalid(10);
        check("sim_level_before", level, 3);
        wr_valid = 1'b1;
        wr_addr  = 32'h2100;
        wr_wdata = 32'h12345678;
        wr_wstrb = 4'h5;
        be_ready = 1'b1;
        step();
        wr_valid = 1'b0;
        be_ready = 1'b0;
        check("sim_level_after", level, 3);
        be_ready = 1'b1;
        wait_empty(100);

        // clock enable low during REQ freezes everything
        be_ready = 1'b0;
        push(32'h3000, 32'hCAFEF00D, 4'h9);
        push(32'h3004, 32'h0BADBEEF, 4'h6);
        wait_avalid(10);
        cke      = 1'b0;
        be_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("cke_avalid", be_avalid, 1'b1);
            check("cke_addr", be_addr, 32'h3000);
            check("cke_wdata", be_wdata, 32'hCAFEF00D);
            check("cke_level", level, 2);
        end
        cke = 1'b1;
        step();
        check("cke_resume_level", level, 1);
        wait_empty(100);

        // reset while a request is outstanding at level 5
        be_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(32'h4000 + 32'(i * 4), 32'($urandom), 4'hF);
        wait_avalid(10);
        check("rst5_level", level, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst5_avalid", be_avalid, 1'b0);
        check("rst5_level_after", level, 0);
        check("rst5_empty", empty, 1'b1);
        check("rst5_be_addr", be_addr, 0);

        // random traffic including clock-enable gaps
        for (int i = 0; i < 300; i++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_addr  = 32'($urandom);
            wr_wdata = 32'($urandom);
            wr_wstrb = 4'($urandom);
            be_ready = 1'($urandom_range(0, 1));
            cke      = ($urandom_range(0, 3) != 0);
            step();
        end
        cke      = 1'b1;
        wr_valid = 1'b0;
        be_ready = 1'b1;
        wait_empty(200);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
